// File: rtl/norm_shift_ctrl_pkg.sv
// Shared FP normalisation definitions: FSM encoding, shift direction constants
// and default single/double precision widths.
package norm_shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ADJUST,
    DONE
  } state_t;

  localparam logic SHIFT_LEFT  = 1'b1;
  localparam logic SHIFT_RIGHT = 1'b0;

  localparam int SP_SW = 26;
  localparam int SP_EW = 8;
  localparam int DP_SW = 55;
  localparam int DP_EW = 11;

  // Number of CW-bit windows needed to cover the SW-1 bits below the carry.
  function automatic int num_windows(input int sw, input int cw);
    return (sw - 1 + cw - 1) / cw;
  endfunction

endpackage

// File: rtl/norm_shift_ctrl_if.sv
// Request/result bundle between the FP adder and the normalisation control.
interface norm_shift_ctrl_if
  import norm_shift_ctrl_pkg::*;
#(
  parameter int SW = SP_SW,
  parameter int EW = SP_EW
);

  logic          start_i;
  logic [SW-1:0] Add_Subt_result_i;
  logic [EW-1:0] exp_i;
  logic          ready_o;
  logic          valid_o;
  logic          load_o;
  logic [EW-1:0] Shift_Value_o;
  logic          FSM_left_right_o;
  logic [EW-1:0] exp_o;
  logic          zero_o;
  logic          underflow_o;
  logic          overflow_o;

  modport master (
    output start_i, Add_Subt_result_i, exp_i,
    input  ready_o, valid_o, load_o, Shift_Value_o, FSM_left_right_o,
    input  exp_o, zero_o, underflow_o, overflow_o
  );

  modport slave (
    input  start_i, Add_Subt_result_i, exp_i,
    output ready_o, valid_o, load_o, Shift_Value_o, FSM_left_right_o,
    output exp_o, zero_o, underflow_o, overflow_o
  );

endinterface

// File: rtl/norm_shift_ctrl_lod_window.sv
// Combinational leading-one detector over a W-bit window; idx counts from the MSB.
module lod_window #(
  parameter int W  = 4,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  win,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan LSB to MSB so the highest set bit is the last one written.
  always_comb begin
    found = |win;
    idx   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (win[i]) idx = IW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/norm_shift_ctrl.sv
// Normalisation control ahead of the barrel shifter: leading-one scan, shift
// amount/direction and exponent correction. NORM_DENORM_EN selects denormal output.
module norm_shift_ctrl
  import norm_shift_ctrl_pkg::*;
#(
  parameter int SW = SP_SW,
  parameter int EW = SP_EW,
  parameter int CW = 4
) (
  input logic             clk,
  input logic             rst,
  norm_shift_ctrl_if.slave bus
);

  localparam int NWIN = num_windows(SW, CW);
  localparam int CNTW = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int IW   = (CW > 1) ? $clog2(CW) : 1;

  state_t          state_q, state_d;
  logic [SW-2:0]   data_q;
  logic [EW-1:0]   exp_q;
  logic [EW-1:0]   lz_q;
  logic [CNTW-1:0] win_q;
  logic            right_q;
  logic            zero_q;

  logic            found;
  logic [IW-1:0]   idx;
  logic            last_win;

  logic [EW-1:0]   adj_shift;
  logic            adj_dir;
  logic [EW-1:0]   adj_exp;
  logic            adj_zero;
  logic            adj_uf;
  logic            adj_of;
  logic [EW:0]     exp_inc;

  // The scan register is shifted left each empty window, so the detector always
  // looks at the top CW bits and zero fill covers a partial last window.
  lod_window #(.W(CW), .IW(IW)) u_lod (
    .win   (data_q[SW-2 -: CW]),
    .found (found),
    .idx   (idx)
  );

  assign last_win = (win_q == CNTW'(NWIN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_i) state_d = bus.Add_Subt_result_i[SW-1] ? ADJUST : SCAN;
      SCAN:    if (found || last_win) state_d = ADJUST;
      ADJUST:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.valid_o = (state_q == DONE);
  assign bus.load_o  = (state_q == DONE);

  always_comb begin
    adj_shift = '0;
    adj_dir   = SHIFT_RIGHT;
    adj_exp   = '0;
    adj_zero  = 1'b0;
    adj_uf    = 1'b0;
    adj_of    = 1'b0;
    exp_inc   = {1'b0, exp_q} + (EW+1)'(1);
    if (right_q) begin
      adj_shift = EW'(1);
      if (exp_inc >= {1'b0, {EW{1'b1}}}) begin
        adj_of  = 1'b1;
        adj_exp = '1;
      end else begin
        adj_exp = exp_inc[EW-1:0];
      end
    end else if (zero_q) begin
      adj_zero = 1'b1;
    end else if (lz_q >= exp_q) begin
      adj_uf  = 1'b1;
      adj_dir = SHIFT_LEFT;
`ifdef NORM_DENORM_EN
      adj_shift = (exp_q == '0) ? '0 : exp_q - EW'(1);
`else
      adj_zero  = 1'b1;
`endif
    end else begin
      adj_shift = lz_q;
      adj_dir   = SHIFT_LEFT;
      adj_exp   = exp_q - lz_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q               <= '0;
      exp_q                <= '0;
      lz_q                 <= '0;
      win_q                <= '0;
      right_q              <= 1'b0;
      zero_q               <= 1'b0;
      bus.Shift_Value_o    <= '0;
      bus.FSM_left_right_o <= 1'b0;
      bus.exp_o            <= '0;
      bus.zero_o           <= 1'b0;
      bus.underflow_o      <= 1'b0;
      bus.overflow_o       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            data_q  <= bus.Add_Subt_result_i[SW-2:0];
            exp_q   <= bus.exp_i;
            lz_q    <= '0;
            win_q   <= '0;
            right_q <= bus.Add_Subt_result_i[SW-1];
            zero_q  <= 1'b0;
          end
        end
        SCAN: begin
          if (found) begin
            lz_q <= lz_q + EW'(idx);
          end else begin
            lz_q   <= lz_q + EW'(CW);
            data_q <= data_q << CW;
            win_q  <= win_q + CNTW'(1);
            if (last_win) zero_q <= 1'b1;
          end
        end
        ADJUST: begin
          bus.Shift_Value_o    <= adj_shift;
          bus.FSM_left_right_o <= adj_dir;
          bus.exp_o            <= adj_exp;
          bus.zero_o           <= adj_zero;
          bus.underflow_o      <= adj_uf;
          bus.overflow_o       <= adj_of;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Directed-vector bench for norm_shift_ctrl (SW=26, EW=8, CW=4).
module tb_norm_shift_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  norm_shift_ctrl_if #(.SW(26), .EW(8)) bus ();

  norm_shift_ctrl #(.SW(26), .EW(8), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] data;
    logic [7:0]  expi;
    int          lat;
    logic        chk_dir;
    logic        dir;
    logic [7:0]  shift;
    logic [7:0]  expo;
    logic        zero;
    logic        uf;
    logic        of;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Issue one request; lat = sampling edges from the start edge to valid_o, -1 on timeout.
  task automatic run_op(input logic [25:0] d, input logic [7:0] e, output int lat);
    @(negedge clk);
    check("ready_before_start", {31'd0, bus.ready_o}, 32'd1);
    bus.start_i           = 1'b1;
    bus.Add_Subt_result_i = d;
    bus.exp_i             = e;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        lat = c;
        break;
      end
    end
    if (lat > 0) begin
      check("load_with_valid", {31'd0, bus.load_o}, 32'd1);
      @(negedge clk);
      check("valid_load_one_cycle", {30'd0, bus.valid_o, bus.load_o}, 32'd0);
    end
  endtask

  task automatic check_results(input vec_t v, input string tag);
    check({tag, "_shift"}, {24'd0, bus.Shift_Value_o}, {24'd0, v.shift});
    check({tag, "_exp"}, {24'd0, bus.exp_o}, {24'd0, v.expo});
    check({tag, "_flags_zuo"}, {29'd0, bus.zero_o, bus.underflow_o, bus.overflow_o},
          {29'd0, v.zero, v.uf, v.of});
    if (v.chk_dir) check({tag, "_dir"}, {31'd0, bus.FSM_left_right_o}, {31'd0, v.dir});
  endtask

  initial begin
    int   lat;
    logic seen;
    checks = 0;
    errors = 0;

    vecs[0] = '{26'h2000000, 8'h80, 2, 1'b1, 1'b0, 8'd1,  8'h81, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{26'h1000000, 8'h7F, 3, 1'b1, 1'b1, 8'd0,  8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{26'h0000100, 8'h80, 7, 1'b1, 1'b1, 8'd16, 8'h70, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{26'h0000000, 8'h80, 9, 1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 1'b0, 1'b0};
`ifdef NORM_DENORM_EN
    vecs[4] = '{26'h0000100, 8'h05, 7, 1'b1, 1'b1, 8'd4,  8'h00, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{26'h1000000, 8'h00, 3, 1'b1, 1'b1, 8'd0,  8'h00, 1'b0, 1'b1, 1'b0};
`else
    vecs[4] = '{26'h0000100, 8'h05, 7, 1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{26'h1000000, 8'h00, 3, 1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 1'b1, 1'b0};
`endif
    vecs[5] = '{26'h2000000, 8'hFE, 2, 1'b1, 1'b0, 8'd1,  8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{26'h0000001, 8'h80, 9, 1'b1, 1'b1, 8'd24, 8'h68, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{26'h0800000, 8'h40, 3, 1'b1, 1'b1, 8'd1,  8'h3F, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{26'h0000800, 8'h80, 6, 1'b1, 1'b1, 8'd13, 8'h73, 1'b0, 1'b0, 1'b0};

    rst                   = 1'b0;
    bus.start_i           = 1'b0;
    bus.Add_Subt_result_i = '0;
    bus.exp_i             = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, bus.ready_o}, 32'd1);
    check("reset_outputs",
          {bus.valid_o, bus.load_o, bus.FSM_left_right_o, bus.zero_o, bus.underflow_o,
           bus.overflow_o, bus.Shift_Value_o, bus.exp_o}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].data, vecs[i].expi, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check_results(vecs[i], $sformatf("v%0d", i));
    end

    // start_i held high through SCAN with different operands must be ignored.
    @(negedge clk);
    bus.start_i           = 1'b1;
    bus.Add_Subt_result_i = 26'h0000000;
    bus.exp_i             = 8'h80;
    @(posedge clk);
    #1;
    bus.Add_Subt_result_i = 26'h2000000;
    bus.exp_i             = 8'hFE;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_not_ready", {31'd0, bus.ready_o}, 32'd0);
      if (c == 2) bus.start_i = 1'b0;
      if (bus.valid_o) begin
        lat = c;
        break;
      end
    end
    check("ignore_start_latency", lat, 9);
    check_results(vecs[3], "ignore_start");
    @(negedge clk);

    // Reset in the middle of a scan, with non-zero results held from a prior op.
    run_op(vecs[2].data, vecs[2].expi, lat);
    check("pre_reset_latency", lat, vecs[2].lat);
    @(negedge clk);
    bus.start_i           = 1'b1;
    bus.Add_Subt_result_i = 26'h0000100;
    bus.exp_i             = 8'h80;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    check("midscan_not_ready", {31'd0, bus.ready_o}, 32'd0);
    rst = 1'b0;
    #1;
    check("async_reset_ready", {31'd0, bus.ready_o}, 32'd1);
    check("async_reset_outputs",
          {bus.valid_o, bus.load_o, bus.FSM_left_right_o, bus.zero_o, bus.underflow_o,
           bus.overflow_o, bus.Shift_Value_o, bus.exp_o}, 32'd0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.valid_o) seen = 1'b1;
    end
    rst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.valid_o) seen = 1'b1;
    end
    check("no_valid_after_abort", {31'd0, seen}, 32'd0);

    run_op(vecs[0].data, vecs[0].expi, lat);
    check("post_reset_latency", lat, vecs[0].lat);
    check_results(vecs[0], "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
